apu_reg_writer: RTL and testbench

//   Write side of the APU register interface. Decodes a byte stream (address/data pairs from the UART

---
 rtl/apu_reg_writer.sv | 113 +++++++++++
 tb/tb_apu_reg_writer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/apu_reg_writer.sv
// APU register writer: turns address/data byte pairs into the $4000-$400F register bank
// and raises a per-channel toggle whenever a channel's trigger register ($4xx3) is written.
module apu_reg_writer #(
  parameter int TIMEOUT = 1000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] reg_bank,
  output logic [3:0]   reg_change,
  output logic         write_strobe,
  output logic         sync_error
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_MAX  = '1;

  typedef enum logic [1:0] {IDLE, DATA, WRITE} state_t;

  state_t         state_q, state_d;
  logic [3:0]     addr_q, addr_d;
  logic [7:0]     data_q, data_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [127:0]   bank_q, bank_d;
  logic [3:0]     chg_q, chg_d;
  logic           strobe_q, strobe_d;
  logic           sync_q, sync_d;
  logic           ready_q, ready_d;
  logic           xfer;

  assign xfer = in_valid & ready_q;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    timer_d  = timer_q;
    bank_d   = bank_q;
    chg_d    = chg_q;
    strobe_d = 1'b0;
    sync_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (in_data[7:4] == 4'b1000) begin
            addr_d  = in_data[3:0];
            timer_d = '0;
            state_d = DATA;
          end else begin
            sync_d = 1'b1;
          end
        end
      end
      DATA: begin
        timer_d = (timer_q == TIMER_MAX) ? timer_q : timer_q + TW'(1);
        // A byte landing on the last allowed cycle still wins over the timeout.
        if (xfer) begin
          data_d  = in_data;
          state_d = WRITE;
        end else if (timer_q == TIMER_LAST) begin
          sync_d  = 1'b1;
          state_d = IDLE;
        end
      end
      WRITE: begin
        bank_d[{addr_q, 3'b000} +: 8] = data_q;
        if (addr_q[1:0] == 2'b11) begin
          chg_d[addr_q[3:2]] = ~chg_q[addr_q[3:2]];
        end
        strobe_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d != WRITE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      timer_q  <= '0;
      bank_q   <= '0;
      chg_q    <= '0;
      strobe_q <= 1'b0;
      sync_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      timer_q  <= timer_d;
      bank_q   <= bank_d;
      chg_q    <= chg_d;
      strobe_q <= strobe_d;
      sync_q   <= sync_d;
      ready_q  <= ready_d;
    end
  end

  assign in_ready     = ready_q;
  assign reg_bank     = bank_q;
  assign reg_change   = chg_q;
  assign write_strobe = strobe_q;
  assign sync_error   = sync_q;

endmodule

// File: tb/tb_apu_reg_writer.sv
// Directed bench for apu_reg_writer: scoreboard of expected register writes checked on each strobe,
// plus timing checks around latency, timeout boundary and mid-pair reset.
module tb_apu_reg_writer;

  localparam int TIMEOUT = 1000;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] reg_bank;
  logic [3:0]   reg_change;
  logic         write_strobe;
  logic         sync_error;

  apu_reg_writer #(.TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .reg_bank     (reg_bank),
    .reg_change   (reg_change),
    .write_strobe (write_strobe),
    .sync_error   (sync_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    logic [3:0] chg;
  } wr_t;

  wr_t          sb[$];
  logic [127:0] exp_bank;
  logic [3:0]   exp_chg;
  int           errors = 0;
  int           checks = 0;
  int           sync_cnt = 0;
  int           strobe_cnt = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns #1 after the edge on which the byte was transferred.
  task automatic send(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 8) begin
      step();
      n++;
    end
    chk("in_ready_before_send", 128'(in_ready), 128'(1));
    step();
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic expect_write(input logic [3:0] a, input logic [7:0] d);
    wr_t w;
    exp_bank[{a, 3'b000} +: 8] = d;
    if (a[1:0] == 2'b11) exp_chg[a[3:2]] = ~exp_chg[a[3:2]];
    w.addr = a;
    w.data = d;
    w.chg  = exp_chg;
    sb.push_back(w);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (sync_error) sync_cnt++;
      if (write_strobe) begin
        wr_t w;
        strobe_cnt++;
        chk("strobe_sync_exclusive", 128'(sync_error), 128'(0));
        chk("sb_has_entry", 128'(sb.size() != 0), 128'(1));
        if (sb.size() != 0) begin
          w = sb.pop_front();
          $display("write: reg $40%h <= %h  reg_change=%b", w.addr, reg_bank[{w.addr, 3'b000} +: 8], reg_change);
          chk("sb_reg_byte", 128'(reg_bank[{w.addr, 3'b000} +: 8]), 128'(w.data));
          chk("sb_reg_change", 128'(reg_change), 128'(w.chg));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int w0;
    int n;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    exp_bank = '0;
    exp_chg  = '0;
    step();
    step();
    chk("reset_reg_bank", reg_bank, 128'(0));
    chk("reset_reg_change", 128'(reg_change), 128'(0));
    chk("reset_write_strobe", 128'(write_strobe), 128'(0));
    chk("reset_sync_error", 128'(sync_error), 128'(0));
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    reset = 1'b0;
    step();

    // 1: single write to $400C and its latency
    send(8'h8C);
    expect_write(4'hC, 8'h1F);
    send(8'h1F);
    chk("t1_no_strobe_at_xfer", 128'(write_strobe), 128'(0));
    chk("t1_byte_not_yet", 128'(reg_bank[103:96]), 128'(0));
    chk("t1_in_ready_low_in_write", 128'(in_ready), 128'(0));
    step();
    chk("t1_byte12", 128'(reg_bank[103:96]), 128'(8'h1F));
    chk("t1_strobe_high", 128'(write_strobe), 128'(1));
    chk("t1_reg_change", 128'(reg_change), 128'(0));
    step();
    chk("t1_strobe_one_cycle", 128'(write_strobe), 128'(0));

    // 2: back-to-back trigger writes to $400F
    send(8'h8F);
    expect_write(4'hF, 8'hA8);
    send(8'hA8);
    send(8'h8F);
    expect_write(4'hF, 8'hA8);
    send(8'hA8);
    step();
    step();
    chk("t2_byte15", 128'(reg_bank[127:120]), 128'(8'hA8));
    chk("t2_reg_change", 128'(reg_change), 128'(0));
    chk("t2_bank", reg_bank, exp_bank);

    // 3: malformed bytes in IDLE
    s0 = sync_cnt;
    w0 = strobe_cnt;
    send(8'h05);
    chk("t3_sync_first", 128'(sync_error), 128'(1));
    send(8'h93);
    chk("t3_sync_second", 128'(sync_error), 128'(1));
    step();
    step();
    chk("t3_sync_count", 128'(sync_cnt - s0), 128'(2));
    chk("t3_no_strobe", 128'(strobe_cnt - w0), 128'(0));
    chk("t3_bank", reg_bank, exp_bank);

    // 4: timeout, then a stray data byte
    s0 = sync_cnt;
    w0 = strobe_cnt;
    send(8'h8E);
    repeat (TIMEOUT - 1) step();
    chk("t4_no_early_timeout", 128'(sync_error), 128'(0));
    step();
    chk("t4_timeout_pulse", 128'(sync_error), 128'(1));
    step();
    chk("t4_pulse_one_cycle", 128'(sync_error), 128'(0));
    send(8'h55);
    chk("t4_discard_pulse", 128'(sync_error), 128'(1));
    step();
    step();
    chk("t4_sync_count", 128'(sync_cnt - s0), 128'(2));
    chk("t4_no_strobe", 128'(strobe_cnt - w0), 128'(0));
    chk("t4_bank", reg_bank, exp_bank);

    // 5: data byte on the last allowed cycle
    s0 = sync_cnt;
    send(8'h8B);
    repeat (TIMEOUT - 1) step();
    expect_write(4'hB, 8'h3C);
    send(8'h3C);
    chk("t5_no_sync", 128'(sync_error), 128'(0));
    step();
    chk("t5_strobe", 128'(write_strobe), 128'(1));
    chk("t5_byte11", 128'(reg_bank[95:88]), 128'(8'h3C));
    chk("t5_reg_change", 128'(reg_change), 128'(4'b0100));
    step();
    chk("t5_sync_count", 128'(sync_cnt - s0), 128'(0));

    // 6: reset during WRITE drops the pair
    send(8'h83);
    send(8'h77);
    reset = 1'b1;
    step();
    exp_bank = '0;
    exp_chg  = '0;
    chk("t6_bank_reset", reg_bank, 128'(0));
    chk("t6_change_reset", 128'(reg_change), 128'(0));
    chk("t6_strobe_reset", 128'(write_strobe), 128'(0));
    chk("t6_sync_reset", 128'(sync_error), 128'(0));
    chk("t6_ready_reset", 128'(in_ready), 128'(1));
    reset = 1'b0;
    step();
    chk("t6_no_late_write", reg_bank, 128'(0));
    send(8'h83);
    expect_write(4'h3, 8'h77);
    send(8'h77);
    step();
    chk("t6_byte3", 128'(reg_bank[31:24]), 128'(8'h77));
    chk("t6_reg_change", 128'(reg_change), 128'(4'b0001));
    step();
    chk("t6_bank", reg_bank, exp_bank);

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      step();
      n++;
    end
    chk("scoreboard_drained", 128'(sb.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
